// File: rtl/iter_divider_pkg.sv
// iter_divider_pkg: shared widths, FSM encoding and word width for the iterative divider
`ifndef XLEN
`define XLEN 64
`endif
`ifndef DXLEN
`define DXLEN 128
`endif
package iter_divider_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int WORD_W = 32;
endpackage

// File: rtl/iter_divider_div_restore_step.sv
// div_restore_step: one radix-2 restoring iteration (rem_in, divisor, dvd_bit -> rem_out, q_bit)
module div_restore_step
  import iter_divider_pkg::*;
#(
  parameter int W = `XLEN
) (
  input  logic [W-1:0] rem_in,
  input  logic [W-1:0] divisor,
  input  logic         dvd_bit,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);
  logic [W:0] sh;
  assign sh = {rem_in, dvd_bit};
  assign q_bit = sh >= {1'b0, divisor};
  assign rem_out = W'(q_bit ? sh - {1'b0, divisor} : sh);
endmodule

// File: rtl/iter_divider.sv
// iter_divider: multi-cycle restoring divider for RV64M DIV/DIVU/REM/REMU and W-variants.
// Ports: clk, rst (async, active-high), flush; in_valid/in_ready with dividend, divisor,
// is_signed, is_word; out_valid/out_ready with quotient, remainder.
// Build option DIV_EARLY_OUT_EN: divide-by-zero, signed overflow and |dividend| < |divisor|
// bypass CALC and present the result one cycle after accept.
module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int W = `XLEN
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  input  logic         is_signed,
  input  logic         is_word,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);
  state_t state, state_n;
  logic [6:0] cnt;
  logic [W-1:0] rem, dvd, dsr, a_ext, b_ext, a_abs, b_abs, step_r, q_pick, r_pick, q_mag, r_mag, q_fin, r_fin;
  logic sq, sr, dz, wd, sa, sb, step_q, msb, last, go_done, early, use_in, fq_neg, fr_neg, fz, fw;

  function automatic logic [W-1:0] ext32(input logic [WORD_W-1:0] v, input logic sgn);
    logic signed [W-1:0] s;
    s = signed'(v);
    return sgn ? s : W'(v);
  endfunction

  assign a_ext = is_word ? ext32(dividend[WORD_W-1:0], is_signed) : dividend;
  assign b_ext = is_word ? ext32(divisor[WORD_W-1:0], is_signed) : divisor;
  assign sa = is_signed & a_ext[W-1];
  assign sb = is_signed & b_ext[W-1];
  assign a_abs = sa ? -a_ext : a_ext;
  assign b_abs = sb ? -b_ext : b_ext;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign use_in = state == IDLE;
  // dvd doubles as the quotient register: dividend bits leave at the top, quotient bits enter at the bottom
  assign msb = wd ? dvd[WORD_W-1] : dvd[W-1];
  assign last = cnt == (wd ? 7'(WORD_W-1) : 7'(W-1));

  div_restore_step #(.W(W)) u_step (
    .rem_in (rem),
    .divisor(dsr),
    .dvd_bit(msb),
    .rem_out(step_r),
    .q_bit  (step_q)
  );

`ifdef DIV_EARLY_OUT_EN
  logic ovf;
  assign ovf = sa & sb & (b_abs == W'(1)) & (a_abs == (W'(1) << (is_word ? WORD_W-1 : W-1)));
  assign early = (b_abs == '0) | ovf | (a_abs < b_abs);
  assign q_pick = use_in ? (ovf ? a_abs : '0) : {dvd[W-2:0], step_q};
  assign r_pick = use_in ? (ovf ? '0 : a_abs) : step_r;
`else
  assign early = 1'b0;
  assign q_pick = {dvd[W-2:0], step_q};
  assign r_pick = step_r;
`endif

  // Sign fixup sources: live operands for an early finish from IDLE, latched flags otherwise.
  // Divide-by-zero remainder and the overflow case fall out of the magnitude path naturally.
  assign fq_neg = use_in ? sa ^ sb : sq;
  assign fr_neg = use_in ? sa : sr;
  assign fz = use_in ? b_abs == '0 : dz;
  assign fw = use_in ? is_word : wd;
  assign q_mag = fz ? '1 : (fq_neg ? -q_pick : q_pick);
  assign r_mag = fr_neg ? -r_pick : r_pick;
  assign q_fin = fw ? ext32(q_mag[WORD_W-1:0], 1'b1) : q_mag;
  assign r_fin = fw ? ext32(r_mag[WORD_W-1:0], 1'b1) : r_mag;

  always_comb begin
    state_n = state;
    go_done = 1'b0;
    if (flush) state_n = IDLE;
    else
      case (state)
        IDLE: if (in_valid) begin
          state_n = early ? DONE : CALC;
          go_done = early;
        end
        CALC: if (last) begin
          state_n = DONE;
          go_done = 1'b1;
        end
        DONE: if (out_ready) state_n = IDLE;
        default: state_n = IDLE;
      endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      rem <= '0;
      dvd <= '0;
      dsr <= '0;
      sq <= 1'b0;
      sr <= 1'b0;
      dz <= 1'b0;
      wd <= 1'b0;
      quotient <= '0;
      remainder <= '0;
    end else begin
      if (state == IDLE && in_valid && !flush) begin
        cnt <= '0;
        rem <= '0;
        dvd <= a_abs;
        dsr <= b_abs;
        sq <= sa ^ sb;
        sr <= sa;
        dz <= b_abs == '0;
        wd <= is_word;
      end else if (state == CALC) begin
        cnt <= cnt + 7'd1;
        rem <= step_r;
        dvd <= {dvd[W-2:0], step_q};
      end
      if (go_done) begin
        quotient <= q_fin;
        remainder <= r_fin;
      end
    end
  end
endmodule

// File: tb/tb_iter_divider.sv
// tb_iter_divider: randomized scoreboard bench for iter_divider against an arithmetic reference model
module tb_iter_divider;
`ifdef DIV_EARLY_OUT_EN
  localparam bit EO = 1'b1;
`else
  localparam bit EO = 1'b0;
`endif
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0, is_signed = 0, is_word = 0;
  logic in_ready, out_valid;
  logic [63:0] dividend = 0, divisor = 0, quotient, remainder;
  typedef struct {logic [63:0] q; logic [63:0] r; int cyc;} exp_t;
  exp_t sb[$];
  exp_t cur;
  int checks = 0, failures = 0, cyc = 0;
  bit hold = 0, busy = 0;

  iter_divider #(.W(64)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .is_signed(is_signed), .is_word(is_word),
    .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #1 out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic void model(input logic [63:0] a, input logic [63:0] b, input bit s, input bit w,
                                output logic [63:0] q, output logic [63:0] r, output bit early);
    logic [63:0] ae, be, aa, ba, minv;
    bit ov;
    ae = w ? (s ? sx(a[31:0]) : {32'b0, a[31:0]}) : a;
    be = w ? (s ? sx(b[31:0]) : {32'b0, b[31:0]}) : b;
    minv = w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    ov = s && ae == minv && be == '1;
    if (be == 0) begin q = '1; r = ae; end
    else if (ov) begin q = ae; r = 0; end
    else if (s) begin q = $signed(ae) / $signed(be); r = $signed(ae) % $signed(be); end
    else begin q = ae / be; r = ae % be; end
    if (w) begin q = sx(q[31:0]); r = sx(r[31:0]); end
    aa = (s && ae[63]) ? -ae : ae;
    ba = (s && be[63]) ? -be : be;
    early = be == 0 || ov || aa < ba;
  endfunction

  function automatic logic [63:0] rnd();
    case ($urandom_range(0, 6))
      0: return 64'($urandom_range(0, 20));
      1: return 64'd0;
      2: return '1;
      3: return 64'h8000_0000_0000_0000;
      4: return {$urandom, 32'h8000_0000};
      5: return {$urandom, $urandom} >> $urandom_range(0, 63);
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic issue(input logic [63:0] a, input logic [63:0] b, input bit s, input bit w, input bit track);
    int n;
    logic [63:0] q, r;
    bit e;
    n = 0;
    while (!in_ready && n < 300) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout in_ready=%b required=1", in_ready);
      return;
    end
    dividend = a; divisor = b; is_signed = s; is_word = w; in_valid = 1;
    model(a, b, s, w, q, r, e);
    if (track) sb.push_back('{q, r, cyc + ((EO && e) ? 1 : (w ? 33 : 65))});
    @(posedge clk); #1;
    in_valid = 0;
    dividend = {$urandom, $urandom};
    divisor = {$urandom, $urandom};
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin @(posedge clk); #1; n++; end
    if (sb.size() != 0 || busy) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout pending=%0d required=0", sb.size());
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst && out_valid) begin
      if (!busy) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out_valid out_valid=%b required=0", out_valid);
        end else begin
          cur = sb.pop_front();
          busy = 1;
          chk("latency_cycle", 64'(cyc), 64'(cur.cyc));
        end
      end
      if (busy) begin
        chk("quotient", quotient, cur.q);
        chk("remainder", remainder, cur.r);
        chk("in_ready_in_done", 64'(in_ready), 64'd0);
      end
      if (out_ready) busy = 0;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog_expired cycles=%0d required_finish=1", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_quotient", quotient, 64'd0);
    chk("reset_remainder", remainder, 64'd0);
    issue(64'd100, 64'd7, 0, 0, 1);
    issue(-64'sd100, 64'd7, 1, 0, 1);
    issue(64'h1234, 64'd0, 1, 0, 1);
    issue(64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1, 1, 1);
    issue(64'd3, 64'd10, 0, 0, 1);
    issue(64'h8000_0000_0000_0000, '1, 1, 0, 1);
    drain();
    hold = 1;
    issue(64'd100, 64'd7, 0, 0, 1);
    n = 0;
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
    chk("backpressure_out_valid", 64'(out_valid), 64'd1);
    repeat (10) @(posedge clk);
    #1 hold = 0;
    drain();
    issue(64'hFFFF_0000_1234_5678, 64'd3, 0, 0, 0);
    repeat (19) @(posedge clk);
    #1 flush = 1;
    @(posedge clk); #1 flush = 0;
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    repeat (70) @(posedge clk);
    #1;
    issue(64'hFFFF_0000_1234_5678, 64'd5, 1, 0, 0);
    repeat (10) @(posedge clk);
    #3 rst = 1;
    #1;
    chk("async_rst_in_ready", 64'(in_ready), 64'd1);
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_quotient", quotient, 64'd0);
    #2 rst = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 120; i++) issue(rnd(), rnd(), $urandom_range(0, 1), $urandom_range(0, 1), 1);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Multi-cycle radix-2 restoring divider; the inverse counterpart of the combinational fast multiplier in the EXU M-extension path.
- Implements RV64M DIV/DIVU/REM/REMU and DIVW/DIVUW/REMW/REMUW.
- Produces quotient and remainder together, with valid/ready handshakes on both sides.
- Abortable by pipeline flush.

Parameters:
- W, `XLEN (64), operand and result width; the only legal values are 32 and 64.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- flush  in  1  abort any in-flight divide; return to IDLE
- in_valid  in  1  operands valid
- in_ready  out  1  divider can accept operands
- dividend  in  W  numerator
- divisor  in  W  denominator
- is_signed  in  1  1 = signed (DIV/REM), 0 = unsigned
- is_word  in  1  1 = 32-bit W-variant, using low 32 bits of the operands
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- quotient  out  W  quotient
- remainder  out  W  remainder

Behaviour:
- Clock and reset: single clock domain; rst is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, counter=0.
- State machine: IDLE -> CALC -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge T, latch the operands, is_signed and is_word, then go to CALC.
  - N = 32 if is_word, else W.
- Operand preparation, at latch time:
  - Word mode: take the low 32 bits of each operand; zero-extend if unsigned, sign-extend if signed.
  - Signed mode: store absolute values; record sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
- CALC:
  - Exactly N cycles; counter counts 0..N-1.
  - Each cycle: rem = {rem[W-1:0], dvd_msb}; if rem >= divisor, subtract and set the quotient bit, else clear it.
  - Partial remainder is W+1 bits wide; quotient is shifted in from the LSB.
  - in_ready=0 throughout.
- DONE:
  - out_valid=1 in cycle T+N+1.
  - quotient and remainder are held stable until out_valid&&out_ready, then return to IDLE on that edge.
  - in_ready=0 in DONE, so there is no overlap of accept and result.
- Sign fixup, applied when entering DONE:
  - Negate quotient if sign_q; negate remainder if sign_r.
- Special cases (RISC-V rules, override the iterative result):
  - divisor==0: quotient = all ones (of the effective width), remainder = dividend.
  - Signed overflow (dividend = most-negative value, divisor = -1): quotient = dividend, remainder = 0.
- Word mode output: 32-bit results sign-extended to W, including DIVUW/REMUW.
- flush:
  - In any state, forces IDLE on the next edge; out_valid drops; the result is discarded.
  - flush has priority over in_valid and out_ready in the same cycle.
- out_ready asserted while not in DONE is ignored.
- Operand inputs are don't-care outside the accept cycle.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- When defined:
  - divisor==0, signed overflow, and |dividend| < |divisor| (unsigned compare of the prepared operands) skip CALC and go IDLE -> DONE directly.
  - out_valid is asserted at T+1.
  - In the |dividend| < |divisor| case: quotient=0, remainder=dividend (word results sign-extended).
- When undefined: every divide takes the full N CALC cycles; results are identical in both builds.

Decomposition:
- Shared header (top.v defines): `XLEN, `DXLEN.
- Local constants: state encoding IDLE/CALC/DONE; word width 32.
- One natural sub-module: div_restore_step.
  - Combinational single restoring iteration.
  - Inputs: partial remainder, divisor, next dividend bit.
  - Outputs: new remainder, quotient bit.
  - Instantiated once in the CALC datapath.

Test Plan:
- Unsigned 64-bit: dividend=100, divisor=7, is_signed=0 -> quotient=14, remainder=2; out_valid exactly 65 cycles after accept (early-out disabled).
- Signed: dividend=-100, divisor=7 -> quotient=-14 (0xFFFF_FFFF_FFFF_FFF2), remainder=-2.
- Divide by zero: dividend=0x1234, divisor=0, is_signed=1 -> quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=0x1234.
- Word mode signed: dividend low32=0x8000_0000, divisor=0xFFFF_FFFF, is_word=1 -> quotient=0xFFFF_FFFF_8000_0000, remainder=0; 33-cycle latency.
- Backpressure and flush:
  - Hold out_ready=0 for 10 cycles after out_valid -> results stable, in_ready stays 0.
  - Separate run: assert flush at CALC cycle 20 -> IDLE next cycle, in_ready=1, no out_valid.
- Async reset: assert rst mid-CALC, asynchronously -> out_valid=0 and in_ready=1 immediately, without waiting for a clock edge.
- With DIV_EARLY_OUT_EN: dividend=3, divisor=10 -> out_valid at T+1, quotient=0, remainder=3.
